// File: rtl/neuron_layer_seq_if.sv
// Bundles the start/activation inputs, the weight/bias ROM port and the result stream of
// neuron_layer_seq. The master modport is the sequencer side; slave is the environment.
interface neuron_layer_seq_if #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 16,
    parameter int unsigned WAW   = 8,
    parameter int unsigned BAW   = 4
) ();
    localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                 start;
    logic [8*N_IN-1:0]    act_in;
    logic [WAW-1:0]       w_addr;
    logic [BAW-1:0]       b_addr;
    logic                 rom_en;
    logic [7:0]           w_data;
    logic [15:0]          b_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [IW-1:0]        out_idx;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, act_in, w_data, b_data, out_ready,
        output w_addr, b_addr, rom_en, out_valid, out_data, out_idx, busy, done
    );

    modport slave (
        output start, act_in, w_data, b_data, out_ready,
        input  w_addr, b_addr, rom_en, out_valid, out_data, out_idx, busy, done
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed 8x8 MAC walks every neuron in turn,
// then applies ReLU/round/saturate and streams the 8-bit result out with valid/ready.
module neuron_layer_seq #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 16,
    parameter int unsigned WAW   = 8,
    parameter int unsigned BAW   = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    neuron_layer_seq_if.master io_bus
);
    localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned KW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StMac, StAct, StEmit} state_e;

    state_e             r_state, w_state_d;
    logic signed [7:0]  r_act [N_IN];
    logic signed [7:0]  w_act_d [N_IN];
    logic [IW-1:0]      r_n, w_n_d;
    logic [KW-1:0]      r_k, w_k_d;
    logic signed [22:0] r_acc, w_acc_d;
    logic [WAW-1:0]     r_w_addr, w_w_addr_d;
    logic [BAW-1:0]     r_b_addr, w_b_addr_d;
    logic               r_rom_en, w_rom_en_d;
    logic               r_out_valid, w_out_valid_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic [7:0]         r_out_data, w_out_data_d;
    logic [IW-1:0]      r_out_idx, w_out_idx_d;

    logic signed [7:0]  w_weight;
    logic signed [15:0] w_prod;
    logic signed [22:0] w_prod_ext;
    logic signed [22:0] w_bias_ext;
    logic [8:0]         w_round;
    logic [7:0]         w_relu;
    logic               w_last_k;
    logic               w_last_n;
    logic               w_handshake;

    assign w_weight    = io_bus.w_data;
    assign w_prod      = r_act[r_k] * w_weight;
    assign w_prod_ext  = {{7{w_prod[15]}}, w_prod};
    assign w_bias_ext  = {{7{io_bus.b_data[15]}}, io_bus.b_data};
    assign w_last_k    = (r_k == KW'(N_IN - 1));
    assign w_last_n    = (r_n == IW'(N_OUT - 1));
    assign w_handshake = r_out_valid && io_bus.out_ready;

    // Round half-down: only a fraction strictly above 1/2 bumps the integer part.
    always_comb begin
        w_round = {1'b0, r_acc[13:6]} + {8'd0, r_acc[5] & (|r_acc[4:0])};
        w_relu  = 8'd0;
        if (r_acc[22]) begin
            w_relu = 8'd0;
        end else if ((|r_acc[21:13]) || (w_round > 9'd127)) begin
            w_relu = 8'd127;
        end else begin
            w_relu = w_round[7:0];
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_act_d       = r_act;
        w_n_d         = r_n;
        w_k_d         = r_k;
        w_acc_d       = r_acc;
        w_w_addr_d    = r_w_addr;
        w_b_addr_d    = r_b_addr;
        w_rom_en_d    = 1'b0;
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
        w_out_idx_d   = r_out_idx;
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    for (int j = 0; j < int'(N_IN); j++) begin
                        w_act_d[j] = io_bus.act_in[8*j +: 8];
                    end
                    w_n_d      = '0;
                    w_w_addr_d = '0;
                    w_b_addr_d = '0;
                    w_rom_en_d = 1'b1;
                    w_busy_d   = 1'b1;
                    w_state_d  = StFetch;
                end
            end
            StFetch: begin
                w_k_d     = '0;
                w_state_d = StMac;
                if (N_IN > 1) begin
                    w_w_addr_d = r_w_addr + 1'b1;
                    w_rom_en_d = 1'b1;
                end
            end
            StMac: begin
                if (r_k == '0) begin
                    w_acc_d = w_bias_ext + w_prod_ext;
                end else begin
                    w_acc_d = r_acc + w_prod_ext;
                end
                if (w_last_k) begin
                    w_state_d = StAct;
                end else begin
                    w_k_d = r_k + 1'b1;
                    // Weight addresses are contiguous across neurons, so a plain increment works.
                    if (int'(r_k) + 2 < int'(N_IN)) begin
                        w_w_addr_d = r_w_addr + 1'b1;
                        w_rom_en_d = 1'b1;
                    end
                end
            end
            StAct: begin
                w_out_data_d  = w_relu;
                w_out_idx_d   = r_n;
                w_out_valid_d = 1'b1;
                w_state_d     = StEmit;
            end
            StEmit: begin
                if (w_handshake) begin
                    w_out_valid_d = 1'b0;
                    if (w_last_n) begin
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_n_d      = r_n + 1'b1;
                        w_w_addr_d = r_w_addr + 1'b1;
                        w_b_addr_d = r_b_addr + 1'b1;
                        w_rom_en_d = 1'b1;
                        w_state_d  = StFetch;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int j = 0; j < int'(N_IN); j++) begin
                r_act[j] <= '0;
            end
            r_n         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
            r_rom_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_act       <= w_act_d;
            r_n         <= w_n_d;
            r_k         <= w_k_d;
            r_acc       <= w_acc_d;
            r_w_addr    <= w_w_addr_d;
            r_b_addr    <= w_b_addr_d;
            r_rom_en    <= w_rom_en_d;
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
            r_out_idx   <= w_out_idx_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    assign io_bus.w_addr    = r_w_addr;
    assign io_bus.b_addr    = r_b_addr;
    assign io_bus.rom_en    = r_rom_en;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_idx   = r_out_idx;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq: arithmetic, rounding edges, timing, back-pressure,
// asynchronous reset mid-pass and ignored start, checked against hand values and a model.
module tb_neuron_layer_seq;
    localparam int unsigned N_IN  = 10;
    localparam int unsigned N_OUT = 16;
    localparam int unsigned WAW   = 8;
    localparam int unsigned BAW   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic signed [7:0]  wrom [256];
    logic signed [15:0] brom [16];
    int                 act_v [N_IN];
    int                 last_out [N_OUT];

    neuron_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WAW(WAW), .BAW(BAW)) bus ();

    neuron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .WAW(WAW), .BAW(BAW)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs: data one cycle after the address.
    always @(posedge clk) begin
        if (bus.rom_en) begin
            bus.w_data <= wrom[bus.w_addr];
            bus.b_data <= brom[bus.b_addr];
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int golden(input int n);
        int acc;
        int q;
        acc = int'(brom[n]);
        for (int k = 0; k < int'(N_IN); k++) begin
            acc += act_v[k] * int'(wrom[n*N_IN + k]);
        end
        if (acc < 0) return 0;
        if (acc >= 8192) return 127;
        q = acc / 64;
        if ((acc % 64) > 32) q++;
        return (q > 127) ? 127 : q;
    endfunction

    task automatic drive_act();
        for (int j = 0; j < int'(N_IN); j++) begin
            bus.act_in[8*j +: 8] = act_v[j][7:0];
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) wrom[i] = 8'($urandom_range(0, 80) - 40);
        for (int i = 0; i < 16; i++) brom[i] = 16'($urandom_range(0, 8000) - 2000);
        for (int j = 0; j < int'(N_IN); j++) act_v[j] = $urandom_range(0, 30) - 5;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_out_valid"}, int'(bus.out_valid), 0);
        check_eq({pfx, "_busy"}, int'(bus.busy), 0);
        check_eq({pfx, "_done"}, int'(bus.done), 0);
        check_eq({pfx, "_rom_en"}, int'(bus.rom_en), 0);
        check_eq({pfx, "_out_data"}, int'(bus.out_data), 0);
        check_eq({pfx, "_out_idx"}, int'(bus.out_idx), 0);
        check_eq({pfx, "_w_addr"}, int'(bus.w_addr), 0);
        check_eq({pfx, "_b_addr"}, int'(bus.b_addr), 0);
    endtask

    // One layer pass; neuron 3 is stalled stall_len cycles. abort_rel>0 resets at that cycle.
    task automatic run_pass(input string name, input int stall_len, input bit poke,
                            input int abort_rel);
        int exp_out [N_OUT];
        int rise [$];
        int dq [$];
        int iq [$];
        int n_done = 0, done_rel = -1, busy_fall = -1;
        int stalled = 0, stall_reads = 0, unstable = 0, idle_bad = 0;
        bit aborted = 1'b0;
        logic prev_valid = 1'b0, prev_busy = 1'b0;
        logic [7:0] hold_data = '0;
        int hold_idx = 0;

        for (int i = 0; i < int'(N_OUT); i++) exp_out[i] = golden(i);
        @(posedge clk); #1;
        drive_act();
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int rel = 1; rel < 400; rel++) begin
            @(negedge clk);
            if (abort_rel > 0 && rel == abort_rel) begin
                check_eq({name, "_no_done_before_reset"}, n_done, 0);
                #2 rst_n = 1'b0;
                #1 check_zero_outputs({name, "_async_rst"});
                aborted = 1'b1;
                break;
            end
            if (rel == 1) check_eq({name, "_busy_cycle1"}, int'(bus.busy), 1);
            if (bus.out_valid && !prev_valid) begin
                rise.push_back(rel);
                hold_data = bus.out_data;
                hold_idx  = int'(bus.out_idx);
            end else if (bus.out_valid &&
                         (bus.out_data != hold_data || int'(bus.out_idx) != hold_idx)) begin
                unstable++;
            end
            if (bus.rom_en && bus.out_valid) stall_reads++;
            if (bus.done) begin
                n_done++;
                done_rel = rel;
            end
            if (prev_busy && !bus.busy) busy_fall = rel;
            prev_valid = bus.out_valid;
            prev_busy  = bus.busy;

            if (bus.out_valid && bus.out_idx == 4'd3 && stalled < stall_len) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                dq.push_back(int'(bus.out_data));
                iq.push_back(int'(bus.out_idx));
            end
            if (poke && rel < 200 && (rel % 17) == 5) begin
                bus.start = 1'b1;
                for (int j = 0; j < int'(N_IN); j++) bus.act_in[8*j +: 8] = 8'($urandom_range(0, 255));
            end else begin
                bus.start = 1'b0;
            end
            if (n_done > 0 && rel >= done_rel + 3) break;
        end
        bus.start = 1'b0;

        if (aborted) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (bus.done || bus.busy) idle_bad++;
            end
            check_eq({name, "_no_done_after_reset"}, idle_bad, 0);
        end else begin
            check_eq({name, "_done_count"}, n_done, 1);
            check_eq({name, "_done_cycle"}, done_rel, 209 + stall_len);
            check_eq({name, "_busy_fall"}, busy_fall, 209 + stall_len);
            check_eq({name, "_n_results"}, dq.size(), N_OUT);
            check_eq({name, "_n_rises"}, rise.size(), N_OUT);
            for (int i = 0; i < int'(N_OUT); i++) begin
                if (i < dq.size()) begin
                    check_eq($sformatf("%s_idx%0d", name, i), iq[i], i);
                    check_eq($sformatf("%s_data%0d", name, i), dq[i], exp_out[i]);
                    last_out[i] = dq[i];
                end
                if (i < rise.size()) begin
                    check_eq($sformatf("%s_rise%0d", name, i), rise[i],
                             13 + 13*i + ((i > 3) ? stall_len : 0));
                end
            end
            check_eq({name, "_hold_stable"}, unstable, 0);
            check_eq({name, "_rom_reads_in_emit"}, stall_reads, 0);
            check_eq({name, "_stall_cycles"}, stalled, stall_len);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        bus.act_in    = '0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Neuron 0: acc = -1536 - 160 - 760 - 310 = -2766 -> 0.
        fill_random();
        for (int j = 0; j < int'(N_IN); j++) act_v[j] = 0;
        act_v[0] = 10; act_v[1] = 20; act_v[2] = -5;
        for (int k = 0; k < int'(N_IN); k++) wrom[k] = 8'sd0;
        wrom[0] = -8'sd16; wrom[1] = -8'sd38; wrom[2] = 8'sd62;
        brom[0] = -16'sd1536;
        run_pass("arith", 0, 1'b0, 0);
        check_eq("arith_n0_hand", last_out[0], 0);

        // act[0]=1, W[0]=1: acc = bias + 1 probes the rounding/saturation edges.
        for (int j = 0; j < int'(N_IN); j++) act_v[j] = 0;
        act_v[0] = 1;
        for (int n = 0; n < 7; n++) begin
            for (int k = 0; k < int'(N_IN); k++) wrom[n*N_IN + k] = 8'sd0;
            wrom[n*N_IN] = 8'sd1;
        end
        brom[0] = 16'sd8063; brom[1] = 16'sd8064; brom[2] = 16'sd8127; brom[3] = 16'sd8191;
        brom[4] = 16'sd8095; brom[5] = 16'sd8096; brom[6] = -16'sd1;
        run_pass("round", 0, 1'b0, 0);
        check_eq("round_8064", last_out[0], 126);
        check_eq("round_8065", last_out[1], 126);
        check_eq("round_8128", last_out[2], 127);
        check_eq("round_8192", last_out[3], 127);
        check_eq("round_half", last_out[4], 126);
        check_eq("round_above_half", last_out[5], 127);
        check_eq("round_neg", last_out[6], 0);

        fill_random();
        run_pass("stall", 5, 1'b0, 0);

        fill_random();
        run_pass("abort", 0, 1'b0, 96);
        run_pass("after_abort", 0, 1'b0, 0);

        fill_random();
        run_pass("poke", 0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
